// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the WISC data-memory responder.
// Optional feature macro: DMEM_ALIGN_CHK_EN (misaligned-access error reporting).
package wisc_mem_pkg;

  localparam int unsigned DMEM_DATA_W         = 16;
  localparam int unsigned DMEM_ADDR_W         = 16;
  localparam int unsigned DMEM_LATENCY_DEF    = 4;
  localparam int unsigned DMEM_DEPTH_LOG2_DEF = 13;
  // Wide enough for LATENCY-1 over the legal LATENCY range 1..15
  localparam int unsigned DMEM_CNT_W          = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the load/store path (master) and the responder (slave).
// Optional feature macro: DMEM_ALIGN_CHK_EN adds the rsp_err signal.
interface dmem_responder_if;
  import wisc_mem_pkg::*;

  logic                   req_valid;
  logic                   req_wr;
  logic [DMEM_ADDR_W-1:0] req_addr;
  logic [DMEM_DATA_W-1:0] req_wdata;
  logic                   req_ready;
  logic                   rsp_valid;
  logic [DMEM_DATA_W-1:0] rsp_rdata;
`ifdef DMEM_ALIGN_CHK_EN
  logic                   rsp_err;
`endif

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
`ifdef DMEM_ALIGN_CHK_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
`ifdef DMEM_ALIGN_CHK_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; no reset, contents undefined after power-up.
module dmem_array
  import wisc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEF
) (
  input  logic                   clk,
  input  logic                   en,
  input  logic                   we,
  input  logic [DEPTH_LOG2-1:0]  idx,
  input  logic [DMEM_DATA_W-1:0] wdata,
  output logic [DMEM_DATA_W-1:0] rdata
);

  logic [DMEM_DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

  // Write or registered read of one word per enabled edge
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for LW/SW; stalls the pipeline until the
// response pulse. Optional feature macro: DMEM_ALIGN_CHK_EN (rsp_err on addr[0]=1,
// access suppressed). LATENCY must lie in 1..15.
module dmem_responder
  import wisc_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DMEM_DEPTH_LOG2_DEF,
  parameter int unsigned LATENCY    = DMEM_LATENCY_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_responder_if.slave bus,
  output logic            stall
);

  localparam logic [DMEM_CNT_W-1:0] CntInit = DMEM_CNT_W'(LATENCY - 1);

  dmem_state_e            state_q, state_d;
  logic [DMEM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
  logic [DMEM_DATA_W-1:0] wdata_q, wdata_d;
  logic                   mis_q, mis_d;
  logic                   req_mis;
  logic                   arr_en;
  logic [DMEM_DATA_W-1:0] arr_rdata;
  logic                   unused_addr;

`ifdef DMEM_ALIGN_CHK_EN
  assign req_mis = bus.req_addr[0];
`else
  assign req_mis = 1'b0;
`endif

  // High address bits alias; bit0 only matters for the alignment check
  assign unused_addr = ^{bus.req_addr[DMEM_ADDR_W-1:DEPTH_LOG2+1], bus.req_addr[0]};

  // Array access happens on the final BUSY edge; misaligned requests never touch it
  assign arr_en = (state_q == StBusy) && (cnt_q == '0) && !mis_q;

  dmem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (wr_q),
    .idx  (idx_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  // State and captured request; async reset aborts any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      mis_q   <= mis_d;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, single RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mis_d   = mis_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          state_d = StBusy;
          cnt_d   = CntInit;
          wr_d    = bus.req_wr;
          idx_d   = bus.req_addr[DEPTH_LOG2:1];
          wdata_d = bus.req_wdata;
          mis_d   = req_mis;
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state; rdata is zero outside a read RESP
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.rsp_valid = (state_q == StResp);
    bus.rsp_rdata = '0;
    if ((state_q == StResp) && !wr_q && !mis_q) begin
      bus.rsp_rdata = arr_rdata;
    end
    stall = (state_q == StBusy) || ((state_q == StIdle) && bus.req_valid);
`ifdef DMEM_ALIGN_CHK_EN
    bus.rsp_err = (state_q == StResp) && mis_q;
`endif
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// a monitor pops and compares on every rsp_valid. Honours DMEM_ALIGN_CHK_EN.
module tb_dmem_responder;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  localparam int Lat = 4;

  logic clk;
  logic rst_n;
  logic stall;

  dmem_responder_if bus ();

  dmem_responder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .stall(stall)
  );

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_rsp    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] rd, input logic err);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    sb_q.push_back(e);
    n_push++;
  endtask

  // Monitor: every response must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rsp_valid) begin
      n_rsp++;
      check("rsp_pending", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
`ifdef DMEM_ALIGN_CHK_EN
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
`endif
      end
    end
  end

  // One full transaction with cycle-accurate stall/ready/valid checks
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input logic exp_err, input string tag);
    @(negedge clk);
    check({tag, "_ready_c0"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    #1;
    check({tag, "_stall_c0"}, 32'(stall), 1);
    push_exp(exp_rd, exp_err);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= Lat; c++) begin
      @(negedge clk);
      check({tag, "_stall_busy"}, 32'(stall), 1);
      check({tag, "_novalid_busy"}, 32'(bus.rsp_valid), 0);
      check({tag, "_ready_busy"}, 32'(bus.req_ready), 0);
    end
    @(negedge clk);
    check({tag, "_valid_c5"}, 32'(bus.rsp_valid), 1);
    check({tag, "_stall_c5"}, 32'(stall), 0);
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(bus.req_ready), 1);
    check({tag, "_rdata_after"}, 32'(bus.rsp_rdata), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 1);
    check("rst_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_stall", 32'(stall), 0);
`ifdef DMEM_ALIGN_CHK_EN
    check("rst_err", 32'(bus.rsp_err), 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back
    do_req(1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, "sw10");
    do_req(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, "lw10");

    // Address bits above the index alias
    do_req(1'b1, 16'h0002, 16'hBEEF, 16'h0000, 1'b0, "sw02");
    do_req(1'b0, 16'h4002, 16'h0000, 16'hBEEF, 1'b0, "lw4002");

    // Hold req_valid through BUSY/RESP with a changed address
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'h0010;
    push_exp(16'h1234, 1'b0);
    @(posedge clk);
    #1 bus.req_addr = 16'h0002;
    for (int c = 1; c <= Lat; c++) begin
      @(negedge clk);
      check("hold_ready_busy", 32'(bus.req_ready), 0);
      check("hold_novalid", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    check("hold_valid_resp", 32'(bus.rsp_valid), 1);
    check("hold_ready_resp", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("hold_ready_idle", 32'(bus.req_ready), 1);
    check("hold_stall_idle", 32'(stall), 1);
    push_exp(16'hBEEF, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= Lat; c++) begin
      @(negedge clk);
      check("hold2_novalid", 32'(bus.rsp_valid), 0);
    end
    @(negedge clk);
    check("hold2_valid", 32'(bus.rsp_valid), 1);
    @(negedge clk);
    check("hold2_ready", 32'(bus.req_ready), 1);

    // Abort: reset in the second BUSY cycle must drop the store
    do_req(1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0, "sw20");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 16'h0020;
    bus.req_wdata = 16'hAAAA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_stall_busy", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.req_ready), 1);
    check("abort_stall", 32'(stall), 0);
    check("abort_valid", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (Lat + 2) @(negedge clk);
    do_req(1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0, "lw20");

`ifdef DMEM_ALIGN_CHK_EN
    do_req(1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, "lw11_err");
    do_req(1'b1, 16'h0011, 16'h7777, 16'h0000, 1'b1, "sw11_err");
    do_req(1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, "lw10_keep");
`else
    do_req(1'b0, 16'h0011, 16'h0000, 16'h1234, 1'b0, "lw11_alias");
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 0);
    check("rsp_count", 32'(n_rsp), 32'(n_push));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
